arith_sequencer: RTL and testbench

Multi-cycle controller for the calculator's arithmetic unit. Accepts one operation (3-bit op code plus two operands) per start pulse, drives the add/sub and shifter configuration lines, and runs each operation for its required number of cycles. ADD/SUB complete in one execute cycle, shifts in one cycle per bit, and MUL/DIV by iterative shift-add and restoring division. Results are held stable with a one-cycle done pulse for the display/register stage downstream.

---
 rtl/arith_sequencer_if.sv | 31 +++
 rtl/arith_sequencer.sv | 165 ++++++++++++++++
 tb/tb_arith_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/arith_sequencer_if.sv
// Request/response bundle between the calculator front end and arith_sequencer.
// The master issues operations; the slave (the sequencer) returns results and datapath config.
interface arith_sequencer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             overflow;
   logic             div_by_zero;
   logic             add_sub;
   logic             left_right;
   logic             logic_arith;

   modport master (
      output start, op, a, b,
      input  busy, done, result, result_hi, overflow, div_by_zero,
      input  add_sub, left_right, logic_arith
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, result_hi, overflow, div_by_zero,
      output add_sub, left_right, logic_arith
   );
endinterface

// File: rtl/arith_sequencer.sv
// Multi-cycle arithmetic sequencer: add/sub, shift-add multiply, restoring divide and
// bit-serial shifts, with registered results and a one-cycle done pulse.
module arith_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   arith_sequencer_if.slave  bus
);
   localparam int unsigned ShW  = $clog2(WIDTH);
   localparam int unsigned CntW = ShW + 1;
   localparam int unsigned Msb  = WIDTH - 1;

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpMul = 3'b010;
   localparam logic [2:0] OpDiv = 3'b011;
   localparam logic [2:0] OpLsl = 3'b100;
   localparam logic [2:0] OpLsr = 3'b101;
   localparam logic [2:0] OpAsl = 3'b110;
   localparam logic [2:0] OpAsr = 3'b111;

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e            state_q;
   logic [2:0]        op_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [CntW-1:0]   cnt_q;
   // hi: MUL high partial product / DIV remainder; lo: MUL multiplier, DIV quotient, shift value
   logic [WIDTH-1:0]  hi_q, lo_q, hi_d, lo_d;
   logic              busy_q, done_q, ovf_q, dbz_q;
   logic              add_sub_q, left_right_q, logic_arith_q;
   logic [WIDTH-1:0]  res_q, res_hi_q;

   logic [WIDTH-1:0]  res_d, res_hi_d, sum, diff;
   logic              ovf_d, dbz_d;
   logic [WIDTH:0]    mul_sum, div_shift;

   function automatic logic [CntW-1:0] n_cycles(input logic [2:0] o, input logic [ShW-1:0] sh);
      if (o == OpMul || o == OpDiv) return CntW'(WIDTH);
      if (o[2] && sh != '0) return CntW'(sh);
      return CntW'(1);
   endfunction

   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      mul_sum   = '0;
      div_shift = '0;
      sum       = a_q + b_q;
      diff      = a_q - b_q;
      res_d     = '0;
      res_hi_d  = '0;
      ovf_d     = 1'b0;
      dbz_d     = 1'b0;
      case (op_q)
         OpAdd: begin
            res_d = sum;
            ovf_d = (a_q[Msb] == b_q[Msb]) && (sum[Msb] != a_q[Msb]);
         end
         OpSub: begin
            res_d = diff;
            ovf_d = (a_q[Msb] != b_q[Msb]) && (diff[Msb] != a_q[Msb]);
         end
         OpMul: begin
            mul_sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
            {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            res_d        = lo_d;
            res_hi_d     = hi_d;
            ovf_d        = |hi_d;
         end
         OpDiv: begin
            // b=0 always "fits", so the quotient fills with ones and a shifts into the remainder
            div_shift = {hi_q, lo_q[WIDTH-1]};
            if (div_shift >= {1'b0, b_q}) begin
               hi_d = WIDTH'(div_shift - {1'b0, b_q});
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = div_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            res_d    = lo_d;
            res_hi_d = hi_d;
            dbz_d    = (b_q == '0);
         end
         default: begin
            if (b_q[ShW-1:0] != '0) begin
               unique case (op_q)
                  OpLsr:   lo_d = lo_q >> 1;
                  OpAsr:   lo_d = {lo_q[Msb], lo_q[WIDTH-1:1]};
                  default: lo_d = lo_q << 1;
               endcase
            end
            res_d = lo_d;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         op_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         cnt_q         <= '0;
         hi_q          <= '0;
         lo_q          <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         res_q         <= '0;
         res_hi_q      <= '0;
         ovf_q         <= 1'b0;
         dbz_q         <= 1'b0;
         add_sub_q     <= 1'b0;
         left_right_q  <= 1'b0;
         logic_arith_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q       <= StExec;
                  busy_q        <= 1'b1;
                  op_q          <= bus.op;
                  a_q           <= bus.a;
                  b_q           <= bus.b;
                  cnt_q         <= n_cycles(bus.op, bus.b[ShW-1:0]);
                  hi_q          <= '0;
                  lo_q          <= (bus.op == OpMul) ? bus.b : bus.a;
                  add_sub_q     <= (bus.op == OpSub);
                  left_right_q  <= (bus.op == OpLsr) || (bus.op == OpAsr);
                  logic_arith_q <= (bus.op == OpAsl) || (bus.op == OpAsr);
               end else begin
                  state_q <= StIdle;
               end
            end
            StExec: begin
               hi_q  <= hi_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) begin
                  state_q  <= StDone;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  res_q    <= res_d;
                  res_hi_q <= res_hi_d;
                  ovf_q    <= ovf_d;
                  dbz_q    <= dbz_d;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.result      = res_q;
   assign bus.result_hi   = res_hi_q;
   assign bus.overflow    = ovf_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.add_sub     = add_sub_q;
   assign bus.left_right  = left_right_q;
   assign bus.logic_arith = logic_arith_q;
endmodule

// File: tb/tb_arith_sequencer.sv
// Directed bench for arith_sequencer: per-op results and latency, handshake corner cases
// and asynchronous reset in the middle of a divide.
module tb_arith_sequencer;
   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpMul = 3'b010;
   localparam logic [2:0] OpDiv = 3'b011;
   localparam logic [2:0] OpLsl = 3'b100;
   localparam logic [2:0] OpLsr = 3'b101;
   localparam logic [2:0] OpAsl = 3'b110;
   localparam logic [2:0] OpAsr = 3'b111;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail = 0;
   int   lat;

   always #5 clk = ~clk;

   arith_sequencer_if #(.WIDTH(8)) bus ();

   arith_sequencer #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input int bound);
      lat = 0;
      while (!bus.done && lat < bound) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   // Called 1 time unit after a clock edge with the DUT idle; returns 1 unit after the
   // edge following done.  cfg = {add_sub, left_right, logic_arith}.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input int exp_lat, input logic [7:0] exp_res,
                         input logic [7:0] exp_hi, input logic exp_ovf, input logic exp_dbz,
                         input logic [2:0] exp_cfg);
      bus.op    = o;
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_eq({tag, "/busy"}, bus.busy, 1);
      check_eq({tag, "/cfg"}, {bus.add_sub, bus.left_right, bus.logic_arith}, exp_cfg);
      wait_done(40);
      check_eq({tag, "/latency"}, lat, exp_lat);
      check_eq({tag, "/result"}, bus.result, exp_res);
      check_eq({tag, "/result_hi"}, bus.result_hi, exp_hi);
      check_eq({tag, "/flags"}, {bus.overflow, bus.div_by_zero, bus.busy}, {exp_ovf, exp_dbz, 1'b0});
      @(posedge clk);
      #1;
      check_eq({tag, "/done_pulse"}, bus.done, 0);
      check_eq({tag, "/hold"}, bus.result, exp_res);
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset/outputs",
               {bus.busy, bus.done, bus.result, bus.result_hi, bus.overflow, bus.div_by_zero,
                bus.add_sub, bus.left_right, bus.logic_arith}, 0);
      rst_n = 1'b1;

      run_op("add",      OpAdd, 8'd100, 8'd50,  1, 8'h96, 8'h00, 1'b1, 1'b0, 3'b000);
      run_op("sub",      OpSub, 8'd5,   8'd7,   1, 8'hFE, 8'h00, 1'b0, 1'b0, 3'b100);
      run_op("sub_ovf",  OpSub, 8'h80,  8'h01,  1, 8'h7F, 8'h00, 1'b1, 1'b0, 3'b100);
      run_op("mul200x3", OpMul, 8'd200, 8'd3,   8, 8'h58, 8'h02, 1'b1, 1'b0, 3'b000);
      run_op("mul15x15", OpMul, 8'd15,  8'd15,  8, 8'hE1, 8'h00, 1'b0, 1'b0, 3'b000);
      run_op("div100_7", OpDiv, 8'd100, 8'd7,   8, 8'd14, 8'd2,  1'b0, 1'b0, 3'b000);
      run_op("div5_0",   OpDiv, 8'd5,   8'd0,   8, 8'hFF, 8'd5,  1'b0, 1'b1, 3'b000);
      run_op("lsr",      OpLsr, 8'h90,  8'd3,   3, 8'h12, 8'h00, 1'b0, 1'b0, 3'b010);
      run_op("asr",      OpAsr, 8'h90,  8'd3,   3, 8'hF2, 8'h00, 1'b0, 1'b0, 3'b011);
      run_op("lsl",      OpLsl, 8'h90,  8'd3,   3, 8'h80, 8'h00, 1'b0, 1'b0, 3'b000);
      run_op("asl",      OpAsl, 8'h90,  8'd3,   3, 8'h80, 8'h00, 1'b0, 1'b0, 3'b001);
      run_op("lsr_b0",   OpLsr, 8'h90,  8'd0,   1, 8'h90, 8'h00, 1'b0, 1'b0, 3'b010);
      run_op("lsl_bhi",  OpLsl, 8'h90,  8'h0B,  3, 8'h80, 8'h00, 1'b0, 1'b0, 3'b000);

      // start held through a MUL, operands scrambled while busy
      bus.op    = OpMul;
      bus.a     = 8'd15;
      bus.b     = 8'd15;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.op = OpAdd;
      bus.a  = 8'hFF;
      bus.b  = 8'hFF;
      wait_done(40);
      check_eq("hold/latency", lat, 8);
      check_eq("hold/result", {bus.result_hi, bus.result}, 16'h00E1);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("hold/single_op", {bus.busy, bus.done}, 2'b00);

      // back-to-back: second start in the done cycle
      bus.op    = OpAdd;
      bus.a     = 8'd100;
      bus.b     = 8'd50;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("b2b/first", {bus.done, bus.result}, {1'b1, 8'h96});
      bus.op    = OpSub;
      bus.a     = 8'd5;
      bus.b     = 8'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check_eq("b2b/accept", {bus.busy, bus.done, bus.add_sub}, 3'b101);
      @(posedge clk);
      #1;
      check_eq("b2b/second", {bus.done, bus.busy, bus.result}, {2'b10, 8'hFE});
      @(posedge clk);
      #1;

      // asynchronous reset during cycle 4 of a DIV
      bus.op    = OpDiv;
      bus.a     = 8'd100;
      bus.b     = 8'd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #4;
      rst_n = 1'b0;
      #1;
      check_eq("rst/outputs",
               {bus.busy, bus.done, bus.result, bus.result_hi, bus.overflow, bus.div_by_zero,
                bus.add_sub, bus.left_right, bus.logic_arith}, 0);
      lat = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.done) lat++;
      end
      rst_n = 1'b1;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (bus.done) lat++;
      end
      check_eq("rst/no_done", lat, 0);
      run_op("post_rst", OpAdd, 8'd1, 8'd1, 1, 8'd2, 8'h00, 1'b0, 1'b0, 3'b000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
